// File: rtl/debounce_pkg.sv
// Shared types and default timing for the push-button debouncer.
// Auto-repeat timing is only consumed when DEBOUNCE_KEYS_AUTOREPEAT_EN is defined.
package debounce_pkg;

    typedef enum logic [1:0] {
        StReleased,
        StPressWait,
        StPressed,
        StReleaseWait
    } key_state_e;

    localparam int unsigned DefNumKeys       = 2;
    localparam int unsigned DefDebounceCycles = 1_000_000;
    localparam int unsigned DefRepeatDelay   = 25_000_000;
    localparam int unsigned DefRepeatPeriod  = 5_000_000;

    // Bits needed to count 0 .. n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One push-button channel: two-flop synchronizer, debounce FSM and pulse outputs.
// DEBOUNCE_KEYS_AUTOREPEAT_EN adds a hold counter that re-issues o_press while held.
module key_debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
    parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_raw_n,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int unsigned     CntW    = cnt_width(DEBOUNCE_CYCLES);
    // The entry edge into a WAIT state is the first stable sample, so the count stops one short.
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 2);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("key_debounce_channel: DEBOUNCE_CYCLES must be >= 2, repeat timings >= 1");
    end

    logic [1:0]      r_sync;
    logic            w_pressed;
    logic            w_repeat;
    key_state_e      r_state;
    logic [CntW-1:0] r_cnt;
    logic            r_level;
    logic            r_press;
    logic            r_release;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_key_raw_n};
        end
    end

    assign w_pressed = ~r_sync[1];

`ifdef DEBOUNCE_KEYS_AUTOREPEAT_EN
    localparam int unsigned      HoldMax         = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                                   REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned      HoldW           = cnt_width(HoldMax);
    localparam logic [HoldW-1:0] HoldLastDelay   = HoldW'(REPEAT_DELAY - 1);
    localparam logic [HoldW-1:0] HoldLastPeriod  = HoldW'(REPEAT_PERIOD - 1);

    logic [HoldW-1:0] r_hold;
    logic             r_hold_periodic;
    logic             w_hold_advance;
    logic             w_hold_hit;

    // Only advances while staying in PRESSED, so RELEASE_WAIT freezes it in place.
    assign w_hold_advance = (r_state == StPressed) && w_pressed;
    assign w_hold_hit     = (r_hold == (r_hold_periodic ? HoldLastPeriod : HoldLastDelay));
    assign w_repeat       = w_hold_advance && w_hold_hit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold          <= '0;
            r_hold_periodic <= 1'b0;
        end else if (r_state == StPressWait) begin
            r_hold          <= '0;
            r_hold_periodic <= 1'b0;
        end else if (w_hold_advance) begin
            if (w_hold_hit) begin
                r_hold          <= '0;
                r_hold_periodic <= 1'b1;
            end else begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= StReleased;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            unique case (r_state)
                StReleased: begin
                    if (w_pressed) begin
                        r_state <= StPressWait;
                        r_cnt   <= '0;
                    end
                end
                StPressWait: begin
                    if (!w_pressed) begin
                        r_state <= StReleased;
                    end else if (r_cnt == CntLast) begin
                        r_state <= StPressed;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StPressed: begin
                    if (!w_pressed) begin
                        r_state <= StReleaseWait;
                        r_cnt   <= '0;
                    end else begin
                        r_press <= w_repeat;
                    end
                end
                StReleaseWait: begin
                    if (w_pressed) begin
                        r_state <= StPressed;
                    end else if (r_cnt == CntLast) begin
                        r_state   <= StReleased;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StReleased;
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/debounce_keys.sv
// Debouncer for NUM_KEYS active-low push buttons with level and press/release pulses.
// Define DEBOUNCE_KEYS_AUTOREPEAT_EN to get repeated KEY_PRESS pulses while a key is held.
module debounce_keys
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = DefNumKeys,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
    parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_KEYS-1:0] KEY_RAW,
    output logic [NUM_KEYS-1:0] KEY_LEVEL,
    output logic [NUM_KEYS-1:0] KEY_PRESS,
    output logic [NUM_KEYS-1:0] KEY_RELEASE
);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .i_clk       (CLK),
            .i_rst       (RST),
            .i_key_raw_n (KEY_RAW[g]),
            .o_level     (KEY_LEVEL[g]),
            .o_press     (KEY_PRESS[g]),
            .o_release   (KEY_RELEASE[g])
        );
    end

endmodule

// File: tb/tb_debounce_keys.sv
// Bench for debounce_keys: directed scenarios plus random key activity against a run-length model.
// Honours DEBOUNCE_KEYS_AUTOREPEAT_EN in its expectations.
module tb_debounce_keys;

    localparam int NK = 2;
    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic [NK-1:0] KEY_RAW;
    logic [NK-1:0] KEY_LEVEL;
    logic [NK-1:0] KEY_PRESS;
    logic [NK-1:0] KEY_RELEASE;

    debounce_keys #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .KEY_RAW     (KEY_RAW),
        .KEY_LEVEL   (KEY_LEVEL),
        .KEY_PRESS   (KEY_PRESS),
        .KEY_RELEASE (KEY_RELEASE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: raw passes a 2-deep delay; a level flips once the last DC samples all disagree with it.
    bit            m_s1    [NK];
    bit            m_s2    [NK];
    bit            m_last  [NK];
    int            m_run   [NK];
    bit            m_level [NK];
    int            m_hold  [NK];
    logic [NK-1:0] e_level;
    logic [NK-1:0] e_press;
    logic [NK-1:0] e_rel;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            m_s1[k] = 1'b1;
            m_s2[k] = 1'b1;
            m_last[k] = 1'b0;
            m_run[k] = 0;
            m_level[k] = 1'b0;
            m_hold[k] = 0;
        end
        e_level = '0;
        e_press = '0;
        e_rel   = '0;
    endtask

    task automatic model_step(input logic [NK-1:0] raw);
        bit p;
        for (int k = 0; k < NK; k++) begin
            p = !m_s2[k];
            if (p == m_last[k]) begin
                if (m_run[k] < 1000) m_run[k]++;
            end else begin
                m_run[k] = 1;
                m_last[k] = p;
            end
            e_press[k] = 1'b0;
            e_rel[k]   = 1'b0;
            if (m_run[k] >= DC && p != m_level[k]) begin
                m_level[k] = p;
                if (p) e_press[k] = 1'b1;
                else   e_rel[k]   = 1'b1;
                m_hold[k] = 0;
            end
`ifdef DEBOUNCE_KEYS_AUTOREPEAT_EN
            // Hold time accrues only on cycles where the key was pressed on both recent samples.
            else if (m_level[k] && p && m_run[k] >= 2) begin
                m_hold[k]++;
                if (m_hold[k] == RD || (m_hold[k] > RD && (m_hold[k] - RD) % RP == 0))
                    e_press[k] = 1'b1;
            end
`endif
            e_level[k] = m_level[k];
            m_s2[k] = m_s1[k];
            m_s1[k] = raw[k];
        end
    endtask

    task automatic step(input logic [NK-1:0] raw);
        KEY_RAW = raw;
        @(posedge CLK);
        model_step(raw);
        #1;
        check_eq("level", 32'(KEY_LEVEL), 32'(e_level));
        check_eq("press", 32'(KEY_PRESS), 32'(e_press));
        check_eq("release", 32'(KEY_RELEASE), 32'(e_rel));
        check_eq("press_and_release", 32'(KEY_PRESS & KEY_RELEASE), 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        RST = 1'b1;
        #1;
        check_eq("rst_async_out", 32'({KEY_LEVEL, KEY_PRESS, KEY_RELEASE}), 32'd0);
        repeat (cycles) @(posedge CLK);
        #1;
        check_eq("rst_held_out", 32'({KEY_LEVEL, KEY_PRESS, KEY_RELEASE}), 32'd0);
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
        int cnt;
        int act;
        int exp_cnt;
        logic [NK-1:0] raw;
        bit seq [6];

        RST = 1'b1;
        KEY_RAW = '1;
        model_reset();
        @(posedge CLK);
        #1;
        do_reset(2);

        repeat (8) step(2'b11);

        // Clean press and release on key 0.
        first = -1; cnt = 0;
        for (int n = 1; n <= 10; n++) begin
            step(2'b10);
            if (KEY_PRESS[0]) begin cnt++; if (first < 0) first = n; end
        end
        check_eq("clean_press_cycle", first, 6);
        check_eq("clean_press_count", cnt, 1);
        check_eq("clean_press_level", 32'(KEY_LEVEL), 32'b01);
        first = -1; cnt = 0;
        for (int n = 1; n <= 10; n++) begin
            step(2'b11);
            if (KEY_RELEASE[0]) begin cnt++; if (first < 0) first = n; end
        end
        check_eq("clean_release_cycle", first, 6);
        check_eq("clean_release_count", cnt, 1);
        check_eq("clean_release_level", 32'(KEY_LEVEL), 32'b00);

        // Bounce on key 1 never long enough to be accepted.
        seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        act = 0;
        for (int n = 0; n < 14; n++) begin
            step({(n < 6) ? seq[n] : 1'b1, 1'b1});
            act += int'(KEY_LEVEL[1]) + int'(KEY_PRESS[1]) + int'(KEY_RELEASE[1]);
        end
        check_eq("bounce_activity", act, 0);

        // Simultaneous press of both keys.
        first = -1; cnt = 0;
        for (int n = 1; n <= 10; n++) begin
            step(2'b00);
            if (KEY_PRESS == 2'b11 && first < 0) first = n;
            if (KEY_PRESS != 2'b11 && KEY_PRESS != 2'b00) cnt++;
        end
        check_eq("simul_press_cycle", first, 6);
        check_eq("simul_split_pulses", cnt, 0);
        check_eq("simul_level", 32'(KEY_LEVEL), 32'b11);
        repeat (10) step(2'b11);

        // Reset in the middle of PRESS_WAIT with key 0 still held.
        cnt = 0;
        for (int n = 1; n <= 5; n++) begin
            step(2'b10);
            cnt += int'(KEY_PRESS[0]);
        end
        check_eq("prewait_no_press", cnt, 0);
        do_reset(2);
        first = -1; cnt = 0;
        for (int n = 1; n <= 10; n++) begin
            step(2'b10);
            if (KEY_PRESS[0]) begin cnt++; if (first < 0) first = n; end
        end
        check_eq("post_rst_press_cycle", first, 6);
        check_eq("post_rst_press_count", cnt, 1);
        repeat (10) step(2'b11);

        // Long hold: auto-repeat pulses only when the feature is built in.
        first = -1; cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            step(2'b10);
            if (KEY_PRESS[0]) begin
                if (first < 0) first = n;
                if (n - first <= 30) cnt++;
            end
        end
`ifdef DEBOUNCE_KEYS_AUTOREPEAT_EN
        exp_cnt = 1 + 1 + (30 - RD) / RP;
`else
        exp_cnt = 1;
`endif
        check_eq("hold_first_press", first, 6);
        check_eq("hold_press_count", cnt, exp_cnt);
        repeat (10) step(2'b11);

        // Random activity, alternating choppy and calm phases, with occasional resets.
        raw = '1;
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NK; k++) begin
                if ($urandom_range(0, 99) < (((n / 500) % 2 == 0) ? 30 : 4)) raw[k] = ~raw[k];
            end
            if ($urandom_range(0, 799) == 0) begin
                KEY_RAW = raw;
                do_reset(1 + $urandom_range(0, 2));
            end
            step(raw);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
